// File: rtl/osc_pkg.sv
// Shared sample width, FSM encoding and trigger-edge helpers for the capture slice.
package osc_pkg;

  localparam int unsigned SAMPLE_W = 10;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POSTTRIG  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Threshold crossing between two consecutive accepted samples (unsigned compare)
  function automatic logic edge_cross(input logic                edge_sel,
                                      input logic [SAMPLE_W-1:0] prev,
                                      input logic [SAMPLE_W-1:0] cur,
                                      input logic [SAMPLE_W-1:0] level);
    if (edge_sel == EDGE_RISING) begin
      return (prev < level) && (cur >= level);
    end
    return (prev > level) && (cur <= level);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// DEPTH x SAMPLE_W simple dual-port RAM: one write port, registered read port.
module sample_ram
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [SAMPLE_W-1:0]      i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [SAMPLE_W-1:0]      o_rd_data
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [SAMPLE_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Only the read register is reset; array contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger ADC capture into a circular buffer with edge-triggered stop.
// Optional hysteresis qualification is enabled by defining TRIG_HYST_EN.
module trigger_capture
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned PRE_SAMPLES = 64,
  parameter int unsigned HYST        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_ready_i,
  input  logic [SAMPLE_W-1:0]      data_i,
  input  logic                     arm_i,
  input  logic [SAMPLE_W-1:0]      trig_level_i,
  input  logic                     trig_edge_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [SAMPLE_W-1:0]      rd_data_o,
  output logic                     busy_o,
  output logic                     triggered_o,
  output logic                     done_o
);

  localparam int unsigned ADDR_W       = $clog2(DEPTH);
  localparam int unsigned POST_SAMPLES = DEPTH - PRE_SAMPLES;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rdy_d;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_trig_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [ADDR_W-1:0]   w_cnt_inc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_vld;
  logic                r_busy;
  logic                r_triggered;
  logic                r_done;
  logic                w_accept;
  logic                w_cross;
  logic                w_hyst_ok;
  logic                w_we;
  logic                w_restart;
  logic                w_trig_hit;

  assign w_accept  = data_ready_i & ~r_rdy_d;
  assign w_cnt_inc = r_cnt + ADDR_W'(1);
  assign w_cross   = r_prev_vld & edge_cross(trig_edge_i, r_prev, data_i, trig_level_i);

`ifdef TRIG_HYST_EN
  localparam int unsigned LVL_MAX = (1 << SAMPLE_W) - 1;

  logic [SAMPLE_W:0]   w_lvl_ext;
  logic [SAMPLE_W:0]   w_hyst_ext;
  logic [SAMPLE_W:0]   w_hi_sum;
  logic [SAMPLE_W-1:0] w_lo_thr;
  logic [SAMPLE_W-1:0] w_hi_thr;
  logic                w_band_hit;
  logic                r_hyst_seen;

  // Re-arm band edges, saturated to the sample range
  assign w_lvl_ext  = {1'b0, trig_level_i};
  assign w_hyst_ext = (SAMPLE_W + 1)'(HYST);
  assign w_hi_sum   = w_lvl_ext + w_hyst_ext;
  assign w_lo_thr   = (w_lvl_ext >= w_hyst_ext) ? SAMPLE_W'(w_lvl_ext - w_hyst_ext) : '0;
  assign w_hi_thr   = w_hi_sum[SAMPLE_W] ? SAMPLE_W'(LVL_MAX) : w_hi_sum[SAMPLE_W-1:0];
  assign w_band_hit = (trig_edge_i == EDGE_RISING) ? (data_i <= w_lo_thr) : (data_i >= w_hi_thr);

  always_ff @(posedge clk_i) begin
    if (rst_i || w_restart) begin
      r_hyst_seen <= 1'b0;
    end else if (w_we && w_band_hit) begin
      r_hyst_seen <= 1'b1;
    end
  end

  assign w_hyst_ok = r_hyst_seen;
`else
  assign w_hyst_ok = 1'b1;
`endif

  // Guard against out-of-range configuration
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (HYST < (1 << SAMPLE_W) && PRE_SAMPLES >= 1 && PRE_SAMPLES < DEPTH
              && (DEPTH & (DEPTH - 1)) == 0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle strobes; arm always wins over a sample
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_restart   = 1'b0;
    w_trig_hit  = 1'b0;
    if (arm_i) begin
      w_restart   = 1'b1;
      w_state_nxt = ST_PRETRIG;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_PRETRIG: begin
          if (w_accept) begin
            w_we      = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == ADDR_W'(PRE_SAMPLES)) begin
              w_state_nxt = ST_WAIT_TRIG;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_WAIT_TRIG: begin
          if (w_accept) begin
            w_we = 1'b1;
            if (w_cross && w_hyst_ok) begin
              w_trig_hit  = 1'b1;
              w_cnt_nxt   = ADDR_W'(1);
              w_state_nxt = (POST_SAMPLES == 1) ? ST_DONE : ST_POSTTRIG;
            end
          end
        end
        ST_POSTTRIG: begin
          if (w_accept) begin
            w_we      = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == ADDR_W'(POST_SAMPLES)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdy_d     <= 1'b0;
      r_wr_ptr    <= '0;
      r_trig_ptr  <= '0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rdy_d <= data_ready_i;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_PRETRIG) || (w_state_nxt == ST_WAIT_TRIG) ||
                 (w_state_nxt == ST_POSTTRIG);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_restart) begin
        r_wr_ptr    <= '0;
        r_prev_vld  <= 1'b0;
        r_triggered <= 1'b0;
      end else begin
        if (w_we) begin
          r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
          r_prev     <= data_i;
          r_prev_vld <= 1'b1;
        end
        if (w_trig_hit) begin
          r_trig_ptr  <= r_wr_ptr;
          r_triggered <= 1'b1;
        end
      end
    end
  end

  // Readout index 0 maps to the oldest retained pre-trigger sample
  assign w_rd_addr = r_trig_ptr - ADDR_W'(PRE_SAMPLES) + rd_addr_i;

  sample_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_we     (w_we),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(data_i),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(rd_data_o)
  );

  assign busy_o      = r_busy;
  assign triggered_o = r_triggered;
  assign done_o      = r_done;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: readout tables plus multi-cycle capture sequences.
module tb_trigger_capture;

`ifdef TRIG_HYST_EN
  localparam bit HYST_BUILD = 1'b1;
`else
  localparam bit HYST_BUILD = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       data_ready_i;
  logic [9:0] data_i;
  logic       arm_i;
  logic [9:0] trig_level_i;
  logic       trig_edge_i;
  logic [7:0] rd_addr_i;
  logic [9:0] rd_data_o;
  logic       busy_o;
  logic       triggered_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [9:0] exp;
  } rd_vec_t;

  rd_vec_t ramp_tbl [8];
  rd_vec_t fall_tbl [9];

  trigger_capture u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_ready_i(data_ready_i),
    .data_i      (data_i),
    .arm_i       (arm_i),
    .trig_level_i(trig_level_i),
    .trig_edge_i (trig_edge_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .busy_o      (busy_o),
    .triggered_o (triggered_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input int b, input int t, input int d);
    check($sformatf("%s/busy", name), int'(busy_o), b);
    check($sformatf("%s/triggered", name), int'(triggered_o), t);
    check($sformatf("%s/done", name), int'(done_o), d);
  endtask

  // One sample: ready held high for 'hold' cycles, then low for one
  task automatic send(input logic [9:0] v, input int hold);
    data_i       = v;
    data_ready_i = 1'b1;
    repeat (hold) tick();
    data_ready_i = 1'b0;
    tick();
  endtask

  task automatic do_arm(input logic edge_sel, input logic [9:0] lvl);
    trig_edge_i  = edge_sel;
    trig_level_i = lvl;
    arm_i        = 1'b1;
    tick();
    arm_i        = 1'b0;
  endtask

  initial begin
    ramp_tbl = '{'{8'd0, 10'd0}, '{8'd1, 10'd8}, '{8'd63, 10'd504}, '{8'd64, 10'd512},
                 '{8'd127, 10'd1016}, '{8'd128, 10'd0}, '{8'd200, 10'd576},
                 '{8'd255, 10'd1016}};
    fall_tbl = '{'{8'd0, 10'd402}, '{8'd61, 10'd463}, '{8'd62, 10'd400}, '{8'd63, 10'd350},
                 '{8'd64, 10'd300}, '{8'd65, 10'd1}, '{8'd100, 10'd36}, '{8'd254, 10'd190},
                 '{8'd255, 10'd191}};

    rst_i = 1'b1; data_ready_i = 1'b0; data_i = '0; arm_i = 1'b0;
    trig_level_i = '0; trig_edge_i = 1'b0; rd_addr_i = '0;
    tick(); tick();
    check_status("reset", 0, 0, 0);
    check("reset/rd_data", int'(rd_data_o), 0);
    rst_i = 1'b0;
    tick();

    // Rising ramp 0,8,16..: trigger on 512, 256 writes total
    do_arm(1'b0, 10'd512);
    check_status("ramp/armed", 1, 0, 0);
    for (int k = 0; k < 64; k++) send(10'(8 * k), 1);
    check_status("ramp/pretrig_done", 1, 0, 0);
    send(10'd512, 1);
    check_status("ramp/trigger", 1, 1, 0);
    for (int k = 65; k < 255; k++) send(10'(8 * k), 1);
    check_status("ramp/before_last", 1, 1, 0);
    send(10'(8 * 255), 1);
    check_status("ramp/done", 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      rd_addr_i = ramp_tbl[i].addr;
      tick();
      check($sformatf("ramp/rd[%0d]", ramp_tbl[i].addr), int'(rd_data_o), int'(ramp_tbl[i].exp));
    end

    // Falling edge at 300 after 400,350; buffer wraps past the trigger
    do_arm(1'b1, 10'd300);
    check_status("fall/rearm", 1, 0, 0);
    for (int k = 0; k < 64; k++) send(10'(400 + k), 1);
    send(10'd400, 1);
    send(10'd350, 1);
    check_status("fall/pre_cross", 1, 0, 0);
    data_i       = 10'd300;
    data_ready_i = 1'b1;
    tick();
    check_status("fall/same_cycle", 1, 1, 0);
    data_ready_i = 1'b0;
    tick();
    for (int j = 1; j < 191; j++) send(10'(j), 1);
    check_status("fall/before_last", 1, 1, 0);
    send(10'd191, 1);
    check_status("fall/done", 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      rd_addr_i = fall_tbl[i].addr;
      tick();
      check($sformatf("fall/rd[%0d]", fall_tbl[i].addr), int'(rd_data_o), int'(fall_tbl[i].exp));
    end

    // Ready held high 5 cycles: one write per rise; PRETRIG crossing on 64th ignored
    do_arm(1'b0, 10'd100);
    for (int k = 0; k < 63; k++) send(10'd0, 5);
    send(10'd200, 5);
    check_status("hold/pretrig_cross", 1, 0, 0);
    send(10'd0, 5);
    send(10'd200, 5);
    check_status("hold/trigger", 1, 1, 0);
    for (int j = 1; j < 191; j++) send(10'd0, 5);
    check_status("hold/before_last", 1, 1, 0);
    send(10'd0, 5);
    check_status("hold/done", 0, 1, 1);

    // Crossing only at PRETRIG sample 10: remains waiting
    do_arm(1'b0, 10'd512);
    for (int k = 0; k < 64; k++) send((k < 10) ? 10'd100 : 10'd600, 1);
    for (int k = 0; k < 5; k++) send(10'd600, 1);
    check_status("pre_only/waiting", 1, 0, 0);

    // Arm coinciding with a sample rise: the sample is discarded
    data_i       = 10'd0;
    data_ready_i = 1'b1;
    arm_i        = 1'b1;
    tick();
    arm_i        = 1'b0;
    data_ready_i = 1'b0;
    tick();
    check_status("arm_sample/armed", 1, 0, 0);
    for (int k = 0; k < 63; k++) send(10'd0, 1);
    send(10'd600, 1);
    check_status("arm_sample/64th_in_pretrig", 1, 0, 0);
    send(10'd0, 1);
    send(10'd600, 1);
    check_status("arm_sample/trigger", 1, 1, 0);

    // Abort mid-POSTTRIG, then reset mid-PRETRIG
    for (int k = 0; k < 5; k++) send(10'd5, 1);
    do_arm(1'b0, 10'd512);
    check_status("abort/rearm", 1, 0, 0);
    for (int k = 0; k < 3; k++) send(10'd7, 1);
    rst_i = 1'b1;
    tick();
    check_status("abort/reset", 0, 0, 0);
    check("abort/rd_data", int'(rd_data_o), 0);
    rst_i = 1'b0;
    tick();
    check_status("abort/idle", 0, 0, 0);

    // Noise around the level: hysteresis build needs a dip to 508 or below first
    do_arm(1'b0, 10'd512);
    for (int k = 0; k < 64; k++) send(10'd520, 1);
    send(10'd510, 1);
    send(10'd513, 1);
    send(10'd510, 1);
    send(10'd513, 1);
    check("hyst/noise", int'(triggered_o), HYST_BUILD ? 0 : 1);
    send(10'd500, 1);
    send(10'd513, 1);
    check_status("hyst/real_edge", 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 256, capture buffer depth in samples (power of two, 16..1024).
REQ-002 SHALL have parameter PRE_SAMPLES, default 64, pre-trigger samples retained (1..DEPTH-1).
REQ-003 SHALL have parameter HYST, default 4, hysteresis band in LSBs (used only under TRIG_HYST_EN).
REQ-004 SHALL have one clock and synchronous, active-high reset: clk_i in 1 (all logic on rising edge), rst_i in 1.
REQ-005 SHALL have ports: data_ready_i in 1 (ADC driver ready level); data_i in 10 (ADC sample).
REQ-006 SHALL have ports: arm_i in 1 (start capture pulse); trig_level_i in 10; trig_edge_i in 1 (0 rising, 1 falling).
REQ-007 SHALL have ports: rd_addr_i in log2(DEPTH) (readout index, 0 = oldest); rd_data_o out 10.
REQ-008 SHALL have ports: busy_o out 1; triggered_o out 1; done_o out 1.

Function
REQ-009 SHALL accept a sample only on the clk_i cycle where data_ready_i rises (registered 0->1); a held-high level SHALL count once.
REQ-010 SHALL implement FSM IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE.
REQ-011 IDLE/DONE: arm_i=1 -> PRETRIG; write pointer, sample counter, prev-valid flag cleared; done_o, triggered_o cleared next cycle.
REQ-012 PRETRIG: each accepted sample written at wr_ptr, wr_ptr+1 mod DEPTH; after PRE_SAMPLES writes -> WAIT_TRIG.
REQ-013 WAIT_TRIG: samples keep being written circularly; first accepted sample meeting the trigger condition is written, its address latched as trig_ptr -> POSTTRIG, triggered_o=1.
REQ-014 Trigger condition rising: prev < trig_level_i and cur >= trig_level_i; falling: prev > trig_level_i and cur <= trig_level_i; unsigned 10-bit compare.
REQ-015 prev SHALL be the previous accepted sample since arming; the first sample after arm SHALL never trigger; conditions in PRETRIG SHALL be ignored while prev still updates.
REQ-016 POSTTRIG: DEPTH-PRE_SAMPLES samples total written including trigger sample; then -> DONE, done_o=1, no further writes.
REQ-017 arm_i in PRETRIG, WAIT_TRIG or POSTTRIG SHALL restart capture as in REQ-011 (abort).
REQ-018 Readout: rd_data_o = mem[(trig_ptr - PRE_SAMPLES + rd_addr_i) mod DEPTH], one clk_i cycle latency; content defined only while done_o=1.
REQ-019 busy_o SHALL be 1 in PRETRIG, WAIT_TRIG, POSTTRIG; 0 otherwise.
REQ-020 A sample-accept and arm_i in the same cycle: arm wins, sample discarded.

Reset
REQ-021 rst_i=1 SHALL force IDLE, busy_o=0, triggered_o=0, done_o=0, rd_data_o=0, pointers/counters 0, next cycle, including mid-capture; memory contents need not clear.

Configuration
REQ-022 Macro TRIG_HYST_EN defined: rising trigger requires a prior accepted sample <= trig_level_i-HYST (saturate 0) since last trigger-arm; falling mirror with trig_level_i+HYST (saturate 1023); REQ-014 compare still applies.
REQ-023 Macro TRIG_HYST_EN undefined: trigger purely per REQ-014; HYST unused, no hysteresis logic synthesized.

Structure
REQ-024 Package osc_pkg SHALL hold SAMPLE_W=10, FSM state encoding, edge encodings EDGE_RISING=0/EDGE_FALLING=1.
REQ-025 Sub-module sample_ram SHALL be a DEPTH x SAMPLE_W simple dual-port RAM, one write port, synchronous read port.

Verification
REQ-026 Defaults, arm, ramp 0,8,16.. rising, level 512 -> trigger on sample 512; rd_addr 64 reads 512; rd_addr 0 reads 0; done_o after 256 writes.
REQ-027 data_ready_i held high 5 cycles per sample -> exactly one write per rise; sample count matches rise count.
REQ-028 Falling edge, level 300, samples 400,350,300 -> trigger at 300; triggered_o set same cycle state enters POSTTRIG.
REQ-029 Crossing occurs during PRETRIG sample 10 only -> no trigger; stays WAIT_TRIG, busy_o=1.
REQ-030 arm_i mid-POSTTRIG, then rst_i mid-PRETRIG -> restart then IDLE, all outputs 0 next cycle.
REQ-031 TRIG_HYST_EN, HYST=4, level 512: noise 510,513,510,513 -> no trigger; 500 then 513 -> trigger at 513.
